// File: rtl/sim_pkg.sv
// Shared run-controller types: FSM states, store-hit kinds and the default tohost address.
// Pure declarations, no logic and no latency.
package sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } run_state_e;

  typedef enum logic [1:0] {
    HIT_NONE,
    HIT_PASS,
    HIT_FAIL
  } hit_kind_e;

  localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;

  function automatic logic is_terminal(input run_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sim_run_ctrl_tohost_match.sv
// Decodes one store port against the tohost address: combinational, zero latency.
// No flow control; the strobe is sampled only by the controller while running.
module tohost_match
  import sim_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = XLEN'(TOHOST_DEFAULT)
) (
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            hit,
  output logic            is_pass,
  output logic            is_fail
);

  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  assign hit     = st_valid && (st_addr == TOHOST_ADDR);
  assign is_pass = hit && (st_data == ONE);
  // Even values (including 0) are neither pass nor fail and get ignored.
  assign is_fail = hit && st_data[0] && (st_data != ONE);

endmodule

// File: rtl/sim_run_ctrl.sv
// Test-run controller: holds the core in reset, runs it, ends on tohost store or timeout.
// Outputs are registered (one cycle after the deciding store); no backpressure, stores are sampled only in RUN.
module sim_run_ctrl
  import sim_pkg::*;
#(
  parameter int unsigned      XLEN           = 32,
  parameter int unsigned      NUM_PORTS      = 1,
  parameter int unsigned      RST_CYCLES     = 4,
  parameter int unsigned      TIMEOUT_CYCLES = 150,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(TOHOST_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_PORTS-1:0]      st_valid,
  input  logic [NUM_PORTS*XLEN-1:0] st_addr,
  input  logic [NUM_PORTS*XLEN-1:0] st_data,
  output logic                      core_reset,
  output logic                      running,
  output logic                      done,
  output logic                      pass,
  output logic [XLEN-2:0]           fail_code,
  output logic [31:0]               cycle_count
);

  logic [NUM_PORTS-1:0] hit, is_pass, is_fail;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_match
    tohost_match #(
      .XLEN        (XLEN),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_match (
      .st_valid (st_valid[g]),
      .st_addr  (st_addr[g*XLEN +: XLEN]),
      .st_data  (st_data[g*XLEN +: XLEN]),
      .hit      (hit[g]),
      .is_pass  (is_pass[g]),
      .is_fail  (is_fail[g])
    );
  end

  run_state_e      state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [31:0]     cnt_q, cnt_d, cnt_inc;
  logic [XLEN-2:0] fcode_q, fcode_d;
  hit_kind_e       sel_kind;
  logic [XLEN-2:0] sel_code;
  logic            core_reset_q, running_q, done_q, pass_q;

  // Walk from the top port down so the lowest qualifying index wins.
  always_comb begin
    sel_kind = HIT_NONE;
    sel_code = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (hit[i] && (is_pass[i] || is_fail[i])) begin
        sel_kind = is_pass[i] ? HIT_PASS : HIT_FAIL;
        sel_code = st_data[i*XLEN+1 +: XLEN-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    fcode_d = fcode_q;
    cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    if (start) begin
      state_d = ST_RST_HOLD;
      hold_d  = 8'(RST_CYCLES);
      cnt_d   = '0;
      fcode_d = '0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (hold_q <= 8'd1) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_inc;
          // A qualifying store in the expiry cycle beats the timeout.
          if (sel_kind == HIT_PASS) begin
            state_d = ST_PASS;
          end else if (sel_kind == HIT_FAIL) begin
            state_d = ST_FAIL;
            fcode_d = sel_code;
          end else if (cnt_inc == 32'(TIMEOUT_CYCLES)) begin
            state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      fcode_q      <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      fcode_q      <= fcode_d;
      core_reset_q <= (state_d != ST_RUN);
      running_q    <= (state_d == ST_RUN);
      done_q       <= is_terminal(state_d);
      pass_q       <= (state_d == ST_PASS);
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fcode_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed run scenarios plus randomized stores/starts/resets
// checked every cycle against a behavioural run model.
module tb_sim_run_ctrl;

  localparam int XL   = 32;
  localparam int NP   = 2;
  localparam int RSTC = 4;
  localparam int TMO  = 150;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  localparam int S_IDLE = 0, S_HOLD = 1, S_RUN = 2, S_PASS = 3, S_FAIL = 4, S_TMO = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic [NP-1:0]    st_valid;
  logic [NP*XL-1:0] st_addr;
  logic [NP*XL-1:0] st_data;
  logic             core_reset, running, done, pass;
  logic [XL-2:0]    fail_code;
  logic [31:0]      cycle_count;

  sim_run_ctrl #(
    .XLEN           (XL),
    .NUM_PORTS      (NP),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TMO),
    .TOHOST_ADDR    (TOHOST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: one step per clock, counting run cycles as plain integers.
  int          m_state = S_IDLE;
  int          m_hold  = 0;
  logic [31:0] m_cycles = '0;
  logic [30:0] m_fail   = '0;
  logic        found;
  logic [31:0] d;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = S_IDLE; m_hold = 0; m_cycles = '0; m_fail = '0;
    end else if (start) begin
      m_state = S_HOLD; m_hold = RSTC; m_cycles = '0; m_fail = '0;
    end else if (m_state == S_HOLD) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
      found = 1'b0;
      for (int p = 0; p < NP; p++) begin
        d = st_data[p*XL +: XL];
        if (!found && st_valid[p] && st_addr[p*XL +: XL] == TOHOST && d[0]) begin
          found = 1'b1;
          if (d == 32'd1) m_state = S_PASS;
          else begin
            m_state = S_FAIL;
            m_fail  = d[31:1];
          end
        end
      end
      if (!found && m_cycles == 32'(TMO)) m_state = S_TMO;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_reset", 64'(core_reset), 64'(m_state != S_RUN));
      chk("running", 64'(running), 64'(m_state == S_RUN));
      chk("done", 64'(done), 64'(m_state == S_PASS || m_state == S_FAIL || m_state == S_TMO));
      chk("pass", 64'(pass), 64'(m_state == S_PASS));
      chk("fail_code", 64'(fail_code), 64'(m_fail));
      chk("cycle_count", 64'(cycle_count), 64'(m_cycles));
    end
  end

  task automatic clr_st();
    st_valid = '0; st_addr = '0; st_data = '0;
  endtask

  task automatic put(input int p, input logic [31:0] a, input logic [31:0] dv);
    st_valid[p]         = 1'b1;
    st_addr[p*XL +: XL] = a;
    st_data[p*XL +: XL] = dv;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_run();
    int k;
    for (k = 0; k < 20; k++) begin
      if (m_state == S_RUN) break;
      @(posedge clk); #1;
    end
    if (k == 20) chk("wait_run_timeout", 64'd0, 64'd1);
  endtask

  // Present one store on port p during RUN cycle n (counting the current cycle as 1).
  task automatic hit_at(input int n, input int p, input logic [31:0] dv);
    repeat (n - 1) begin @(posedge clk); #1; end
    put(p, TOHOST, dv);
    @(posedge clk); #1 clr_st();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clr_st();
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_run", 64'(running), 64'd0);

    // Pass on port 0 at run cycle 10.
    pulse_start(); wait_run(); hit_at(10, 0, 32'd1);
    @(negedge clk);
    chk("A_pass", 64'(pass), 64'd1);
    chk("A_count", 64'(cycle_count), 64'd10);

    // Fail code 7 >> 1.
    pulse_start(); wait_run(); hit_at(5, 0, 32'h0000_0007);
    @(negedge clk);
    chk("B_fail_code", 64'(fail_code), 64'd3);
    chk("B_done", 64'(done), 64'd1);
    chk("B_pass", 64'(pass), 64'd0);

    // No tohost store: timeout after 150 run cycles, then sticky.
    pulse_start(); wait_run();
    repeat (160) @(posedge clk);
    #1;
    chk("C_done", 64'(done), 64'd1);
    chk("C_pass", 64'(pass), 64'd0);
    chk("C_count", 64'(cycle_count), 64'd150);

    // Same-cycle hits: port 0 (5) wins over port 1 (1).
    pulse_start(); wait_run();
    repeat (2) begin @(posedge clk); #1; end
    put(0, TOHOST, 32'd5); put(1, TOHOST, 32'd1);
    @(posedge clk); #1 clr_st();
    @(negedge clk);
    chk("D_fail_code", 64'(fail_code), 64'd2);
    chk("D_pass", 64'(pass), 64'd0);

    // Even data ignored; pass in the exact expiry cycle beats timeout.
    pulse_start(); wait_run(); hit_at(20, 0, 32'd2);
    @(negedge clk);
    chk("E_even_running", 64'(running), 64'd1);
    @(posedge clk); #1;
    hit_at(129, 1, 32'd1);
    @(negedge clk);
    chk("E_pass", 64'(pass), 64'd1);
    chk("E_count", 64'(cycle_count), 64'd150);

    // Reset mid-run, then a fresh run.
    pulse_start(); wait_run();
    repeat (49) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("F_same_cycle_idle", 64'(running), 64'd0);
    @(negedge clk);
    chk("F_core_reset", 64'(core_reset), 64'd1);
    chk("F_count", 64'(cycle_count), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("F_stay_idle", 64'(core_reset), 64'd1);
    pulse_start(); wait_run();
    @(negedge clk);
    chk("F_fresh_count", 64'(cycle_count), 64'd0);

    // Randomized starts, stores and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 599) != 0);
      start = ($urandom_range(0, 59) == 0);
      clr_st();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 15) == 0)
          put(p, ($urandom_range(0, 3) == 0) ? TOHOST : 32'($urandom),
              ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 9)) : 32'($urandom));
      end
    end
    @(posedge clk); #1 reset = 1'b1; start = 1'b0; clr_st();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
